// File: rtl/ivs_slot_pkg.sv
// Shared definitions for the slot scheduler: slot geometry and FSM state encodings.
package ivs_slot_pkg;

    localparam int unsigned SLOT_NUM = 32;
    localparam int unsigned SLOT_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_CMD = 3'd2,
        ST_START    = 3'd3,
        ST_RUN      = 3'd4,
        ST_DONE     = 3'd5
    } sched_state_e;

    // Next slot index, wrapping 31 -> 0.
    function automatic logic [SLOT_W-1:0] slot_next(input logic [SLOT_W-1:0] s);
        return s + SLOT_W'(1);
    endfunction

endpackage

// File: rtl/ivs_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping 31 -> 0.
module ivs_rr_pick
    import ivs_slot_pkg::*;
(
    input  logic [SLOT_NUM-1:0] req_i,
    input  logic [SLOT_W-1:0]   ptr_i,
    output logic [SLOT_W-1:0]   idx_o,
    output logic                vld_o
);

    logic [SLOT_NUM-1:0] rot;
    logic [SLOT_W-1:0]   off;

    // Rotate so the pointer position lands at bit 0; lowest set bit is then the winner.
    assign rot = SLOT_NUM'({req_i, req_i} >> ptr_i);

    always_comb begin
        off = '0;
        for (int i = int'(SLOT_NUM) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SLOT_W'(i);
            end
        end
    end

    assign idx_o = ptr_i + off;
    assign vld_o = |req_i;

endmodule

// File: rtl/ivs_slot_sched.sv
// Slot scheduler: picks pending slots round-robin and sequences command fetch and frame run.
// Frame watchdog is built only when IVS_SLOT_SCHED_WDT_EN is defined.
module ivs_slot_sched
    import ivs_slot_pkg::*;
#(
    parameter int unsigned WDT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sched_en,
    input  logic                slot_post,
    input  logic [SLOT_W-1:0]   slot_post_id,
    output logic                slot_fetch_en,
    output logic [SLOT_W-1:0]   slot_sel_dec,
    input  logic                dma_cmd_resp,
    output logic                frm_start,
    input  logic                frm_done,
    output logic                slot_done,
    output logic [SLOT_W-1:0]   slot_done_id,
    output logic [SLOT_NUM-1:0] slot_pend,
    output logic                sched_busy,
    input  logic [WDT_W-1:0]    wdt_limit,
    input  logic                wdt_clr,
    output logic                wdt_err
);

    sched_state_e        state_q;
    logic [SLOT_NUM-1:0] pend_q;
    logic [SLOT_NUM-1:0] pend_d;
    logic [SLOT_W-1:0]   rr_ptr_q;
    logic [SLOT_W-1:0]   sel_q;
    logic [SLOT_W-1:0]   done_id_q;
    logic [SLOT_W-1:0]   pick_idx;
    logic                pick_vld;
    logic                fetch_q;
    logic                start_q;
    logic                done_q;
    logic                busy_q;
    logic                wdt_to_c;

    ivs_rr_pick u_rr_pick (
        .req_i (pend_q),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    // Pending bitmap: a post lands after the DONE clear, so a same-cycle repost survives.
    always_comb begin
        pend_d = pend_q;
        if (state_q == ST_DONE) begin
            pend_d[sel_q] = 1'b0;
        end
        if (slot_post) begin
            pend_d[slot_post_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            sel_q     <= '0;
            done_id_q <= '0;
            fetch_q   <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            fetch_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sched_en && pick_vld) begin
                        sel_q   <= pick_idx;
                        fetch_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_WAIT_CMD;
                end
                ST_WAIT_CMD: begin
                    if (dma_cmd_resp) begin
                        start_q <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (frm_done || wdt_to_c) begin
                        done_q    <= 1'b1;
                        done_id_q <= sel_q;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rr_ptr_q <= slot_next(sel_q);
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef IVS_SLOT_SCHED_WDT_EN
    logic [WDT_W-1:0] wdt_cnt_q;
    logic [WDT_W-1:0] wdt_cnt_d;
    logic             wdt_err_q;

    // Timeout fires in the RUN cycle whose increment reaches the limit.
    assign wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
    assign wdt_to_c  = (state_q == ST_RUN) && (wdt_limit != '0) && (wdt_cnt_d == wdt_limit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdt_cnt_q <= '0;
            wdt_err_q <= 1'b0;
        end else begin
            if (state_q == ST_START) begin
                wdt_cnt_q <= '0;
            end else if (state_q == ST_RUN) begin
                wdt_cnt_q <= wdt_cnt_d;
            end
            if (wdt_to_c) begin
                wdt_err_q <= 1'b1;
            end else if (wdt_clr) begin
                wdt_err_q <= 1'b0;
            end
        end
    end

    assign wdt_err = wdt_err_q;
`else
    logic unused_wdt;

    assign unused_wdt = ^{wdt_limit, wdt_clr};
    assign wdt_to_c   = 1'b0;
    assign wdt_err    = 1'b0;
`endif

    assign slot_fetch_en = fetch_q;
    assign slot_sel_dec  = sel_q;
    assign frm_start     = start_q;
    assign slot_done     = done_q;
    assign slot_done_id  = done_id_q;
    assign slot_pend     = pend_q;
    assign sched_busy    = busy_q;

endmodule

// File: tb/tb_ivs_slot_sched.sv
// Bench for ivs_slot_sched: vector table, directed corner sequences, randomized run vs reference model.
module tb_ivs_slot_sched;

    localparam int unsigned WDT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sched_en = 1'b0;
    logic             slot_post = 1'b0;
    logic [4:0]       slot_post_id = '0;
    logic             slot_fetch_en;
    logic [4:0]       slot_sel_dec;
    logic             dma_cmd_resp = 1'b0;
    logic             frm_start;
    logic             frm_done = 1'b0;
    logic             slot_done;
    logic [4:0]       slot_done_id;
    logic [31:0]      slot_pend;
    logic             sched_busy;
    logic [WDT_W-1:0] wdt_limit = '0;
    logic             wdt_clr = 1'b0;
    logic             wdt_err;

    ivs_slot_sched #(.WDT_W(WDT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sched_en      (sched_en),
        .slot_post     (slot_post),
        .slot_post_id  (slot_post_id),
        .slot_fetch_en (slot_fetch_en),
        .slot_sel_dec  (slot_sel_dec),
        .dma_cmd_resp  (dma_cmd_resp),
        .frm_start     (frm_start),
        .frm_done      (frm_done),
        .slot_done     (slot_done),
        .slot_done_id  (slot_done_id),
        .slot_pend     (slot_pend),
        .sched_busy    (sched_busy),
        .wdt_limit     (wdt_limit),
        .wdt_clr       (wdt_clr),
        .wdt_err       (wdt_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]  id;
        int          rd;
        int          fd;
        int          exp_fetch_lat;
        logic [4:0]  exp_sel;
        logic [31:0] exp_pend;
    } vec_t;

    vec_t        tbl[5];
    int          lat;
    logic [4:0]  sel;
    int          cnt;
    int          order[3];

    // Reference model state for the randomized run
    logic [31:0] pend_m;
    logic [31:0] pend_n;
    int          ptr_m;
    int          cur;
    logic [4:0]  sel_m;
    logic [4:0]  done_id_m;
    logic        idle_c;
    logic        launch;
    int          t_fetch, t_resp, t_start, t_fd, t_done;
    logic        en_r, post_b, resp_b, fd_b, in_wait, in_run;
    logic [4:0]  id_b;
    logic [46:0] exp_v, act_v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic int pick(input logic [31:0] p, input int ptr);
        for (int k = 0; k < 32; k++) begin
            int i;
            i = (ptr + k) % 32;
            if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        slot_post    = 1'b0;
        dma_cmd_resp = 1'b0;
        frm_done     = 1'b0;
        wdt_clr      = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic post(input logic [4:0] id);
        slot_post    = 1'b1;
        slot_post_id = id;
        @(negedge clk);
        slot_post    = 1'b0;
    endtask

    task automatic wait_fetch(input string tag, input int budget, output int l, output logic [4:0] s);
        l = -1;
        s = '0;
        for (int i = 0; i < budget; i++) begin
            if (slot_fetch_en) begin
                l = i;
                s = slot_sel_dec;
                break;
            end
            @(negedge clk);
        end
        chk({tag, " fetch_seen"}, 64'(l >= 0), 64'(1));
    endtask

    // Called at the negedge of a fetch cycle; plays command manager and frame engine.
    task automatic serve(input int rd, input int fd, input logic [4:0] exp_id, input int repost,
                         input string tag);
        @(negedge clk);
        slot_post = 1'b0;
        chk({tag, " fetch_one_cycle"}, 64'(slot_fetch_en), 64'(0));
        repeat (rd) @(negedge clk);
        dma_cmd_resp = 1'b1;
        @(negedge clk);
        dma_cmd_resp = 1'b0;
        chk({tag, " frm_start"}, 64'(frm_start), 64'(1));
        @(negedge clk);
        chk({tag, " frm_start_one_cycle"}, 64'({frm_start, sched_busy}), 64'(2'b01));
        repeat (fd) @(negedge clk);
        frm_done = 1'b1;
        @(negedge clk);
        frm_done = 1'b0;
        if (repost >= 0) begin
            slot_post    = 1'b1;
            slot_post_id = 5'(repost);
        end
        chk({tag, " slot_done"}, 64'({slot_done, slot_done_id}), 64'({1'b1, exp_id}));
        @(negedge clk);
        slot_post = 1'b0;
        chk({tag, " back_idle"}, 64'({slot_done, sched_busy}), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{5'd7,  0, 0, 2, 5'd7,  32'h0};
        tbl[1] = '{5'd0,  3, 2, 2, 5'd0,  32'h0};
        tbl[2] = '{5'd31, 1, 5, 2, 5'd31, 32'h0};
        tbl[3] = '{5'd16, 2, 0, 2, 5'd16, 32'h0};
        tbl[4] = '{5'd9,  0, 1, 2, 5'd9,  32'h0};
        order[0] = 30;
        order[1] = 3;
        order[2] = 9;

        @(negedge clk);
        do_reset();
        chk("reset_state", 64'({slot_fetch_en, frm_start, slot_done, slot_done_id, slot_sel_dec,
                                sched_busy, wdt_err, slot_pend}), 64'(0));
        sched_en = 1'b1;

        // Single-slot vectors; last one leaves the pointer at 10
        for (int k = 0; k < 5; k++) begin
            post(tbl[k].id);
            wait_fetch("tbl", 10, lat, sel);
            chk("tbl fetch_latency", 64'(lat + 1), 64'(tbl[k].exp_fetch_lat));
            chk("tbl sel", 64'(sel), 64'(tbl[k].exp_sel));
            serve(tbl[k].rd, tbl[k].fd, tbl[k].exp_sel, -1, "tbl");
            chk("tbl pend_after", 64'(slot_pend), 64'(tbl[k].exp_pend));
        end

        // Round-robin from pointer 10 over {3,9,30}
        sched_en = 1'b0;
        post(5'd3);
        post(5'd9);
        post(5'd30);
        chk("rr pend", 64'(slot_pend), 64'(32'h4000_0208));
        sched_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_fetch("rr", 10, lat, sel);
            chk("rr order", 64'(sel), 64'(order[k]));
            serve(1, 0, 5'(order[k]), -1, "rr");
        end
        chk("rr pend_empty", 64'(slot_pend), 64'(0));

        // Repost of slot 5 during its own DONE cycle
        post(5'd5);
        wait_fetch("coll", 10, lat, sel);
        chk("coll sel", 64'(sel), 64'(5));
        serve(0, 0, 5'd5, 5, "coll");
        chk("coll pend_kept", 64'(slot_pend), 64'(32'h20));
        wait_fetch("coll2", 10, lat, sel);
        chk("coll second_run", 64'(sel), 64'(5));
        serve(0, 0, 5'd5, -1, "coll2");
        chk("coll pend_empty", 64'(slot_pend), 64'(0));

        // Enable gating and mid-slot disable
        sched_en = 1'b0;
        post(5'd2);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (slot_fetch_en || sched_busy) cnt++;
            @(negedge clk);
        end
        chk("gate no_launch", 64'(cnt), 64'(0));
        chk("gate pend", 64'(slot_pend), 64'(32'h4));
        sched_en = 1'b1;
        wait_fetch("gate", 5, lat, sel);
        chk("gate sel", 64'(sel), 64'(2));
        slot_post    = 1'b1;
        slot_post_id = 5'd12;
        sched_en     = 1'b0;
        serve(1, 1, 5'd2, -1, "gate_mid");
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (slot_fetch_en) cnt++;
            @(negedge clk);
        end
        chk("gate held_after_slot", 64'(cnt), 64'(0));
        chk("gate pend12", 64'(slot_pend), 64'(32'h1000));
        sched_en = 1'b1;
        wait_fetch("gate2", 5, lat, sel);
        chk("gate2 sel", 64'(sel), 64'(12));
        serve(0, 0, 5'd12, -1, "gate2");

`ifdef IVS_SLOT_SCHED_WDT_EN
        wdt_limit = WDT_W'(50);
        post(5'd20);
        wait_fetch("wdt", 10, lat, sel);
        @(negedge clk);
        dma_cmd_resp = 1'b1;
        @(negedge clk);
        dma_cmd_resp = 1'b0;
        chk("wdt frm_start", 64'(frm_start), 64'(1));
        cnt = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (slot_done) begin
                cnt = i;
                break;
            end
        end
        chk("wdt start_to_done_cycles", 64'(cnt), 64'(51));
        chk("wdt done", 64'({wdt_err, slot_done_id}), 64'({1'b1, 5'd20}));
        @(negedge clk);
        chk("wdt sticky_and_cleared", 64'({wdt_err, slot_pend}), 64'({1'b1, 32'h0}));
        wdt_clr = 1'b1;
        @(negedge clk);
        wdt_clr = 1'b0;
        chk("wdt clr", 64'(wdt_err), 64'(0));
        wdt_clr = 1'b1;
        post(5'd21);
        wait_fetch("wdt2", 10, lat, sel);
        @(negedge clk);
        dma_cmd_resp = 1'b1;
        @(negedge clk);
        dma_cmd_resp = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (slot_done) begin
                cnt = i;
                break;
            end
        end
        chk("wdt set_beats_clr", 64'({wdt_err, 8'(cnt)}), 64'({1'b1, 8'd51}));
        @(negedge clk);
        chk("wdt clr_after", 64'(wdt_err), 64'(0));
        wdt_clr   = 1'b0;
        wdt_limit = '0;
`else
        wdt_limit = WDT_W'(5);
        post(5'd20);
        wait_fetch("nowdt", 10, lat, sel);
        serve(0, 20, 5'd20, -1, "nowdt");
        chk("nowdt err", 64'(wdt_err), 64'(0));
        wdt_limit = '0;
`endif

        // Reset in RUN, then a stray frm_done
        post(5'd14);
        wait_fetch("rst", 10, lat, sel);
        @(negedge clk);
        dma_cmd_resp = 1'b1;
        @(negedge clk);
        dma_cmd_resp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst busy_in_run", 64'({sched_busy, slot_sel_dec}), 64'({1'b1, 5'd14}));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst mid_run", 64'({slot_fetch_en, frm_start, slot_done, slot_done_id, slot_sel_dec,
                                sched_busy, wdt_err, slot_pend}), 64'(0));
        frm_done = 1'b1;
        @(negedge clk);
        frm_done = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (slot_done || sched_busy || slot_fetch_en || frm_start) cnt++;
            @(negedge clk);
        end
        chk("rst stray_frm_done", 64'(cnt), 64'(0));

        // Randomized run against the reference model
        do_reset();
        pend_m = '0; ptr_m = 0; cur = 0; sel_m = '0; done_id_m = '0; idle_c = 1'b1;
        t_fetch = -100; t_resp = -100; t_start = -100; t_fd = -100; t_done = -100;
        en_r = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            exp_v = {c == t_fetch, c == t_start, c == t_done, done_id_m, sel_m, !idle_c, 1'b0, pend_m};
            act_v = {slot_fetch_en, frm_start, slot_done, slot_done_id, slot_sel_dec,
                     sched_busy, wdt_err, slot_pend};
            chk("rand cycle", 64'(act_v), 64'(exp_v));
            if ($urandom_range(39) == 0) en_r = !en_r;
            post_b  = ($urandom_range(5) == 0);
            id_b    = 5'($urandom_range(31));
            in_wait = !idle_c && (c > t_fetch) && (c <= t_resp);
            in_run  = !idle_c && (c > t_start) && (c <= t_fd);
            resp_b  = in_wait ? (c == t_resp) : ($urandom_range(7) == 0);
            fd_b    = in_run ? (c == t_fd) : ($urandom_range(7) == 0);
            sched_en     = en_r;
            slot_post    = post_b;
            slot_post_id = id_b;
            dma_cmd_resp = resp_b;
            frm_done     = fd_b;

            launch = idle_c && en_r && (pend_m != 0);
            pend_n = pend_m;
            if (!idle_c && c == t_done) begin
                pend_n[cur] = 1'b0;
                ptr_m = (cur + 1) % 32;
            end
            if (post_b) pend_n[id_b] = 1'b1;
            if (c + 1 == t_done) done_id_m = 5'(cur);
            if (launch) begin
                cur     = pick(pend_m, ptr_m);
                sel_m   = 5'(cur);
                t_fetch = c + 1;
                t_resp  = t_fetch + 1 + int'($urandom_range(3));
                t_start = t_resp + 1;
                t_fd    = t_start + 1 + int'($urandom_range(4));
                t_done  = t_fd + 1;
            end
            idle_c = idle_c ? !launch : (c == t_done);
            pend_m = pend_n;
            @(negedge clk);
        end
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
